// File: rtl/measure_result_packer.sv
// measure_result_packer
//   Packs one measurement result (frequency, duty, high/low time) into a byte
//   frame and streams it over a valid/ready byte interface. The frame is
//   HDR0 HDR1 FRAME_TYPE [SEQ] freq[4] duty {4'h0,high}[3] {4'h0,low}[3] CS.
//   Multi-byte fields go MSB first. CS is the modulo-256 sum of FRAME_TYPE
//   through the last low byte. A one-deep pending slot buffers a result that
//   arrives mid-frame. A newer arrival overwrites the slot and counts a drop.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   finish    one-cycle pulse, result inputs valid in the same cycle
//   freq_in   measured frequency in Hz (32 bits)
//   duty_in   duty cycle in % (8 bits)
//   high_in   high time in clock cycles (20 bits)
//   low_in    low time in clock cycles (20 bits)
//   tx_data   current frame byte
//   tx_valid  tx_data valid
//   tx_ready  downstream accepts the byte
//   busy      frame in flight or result pending
//   drop_cnt  discarded results, saturating at 255
//
// Configuration
//   PACKER_SEQ_NUM_EN  when defined, a sequence byte follows FRAME_TYPE
//                      (16-byte frames). The sequence byte is included in CS
//                      and advances once per frame started.
module measure_result_packer #(
  parameter logic [7:0] HDR0       = 8'hA5,
  parameter logic [7:0] HDR1       = 8'h5A,
  parameter logic [7:0] FRAME_TYPE = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish,
  input  logic [31:0] freq_in,
  input  logic [7:0]  duty_in,
  input  logic [19:0] high_in,
  input  logic [19:0] low_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

`ifdef PACKER_SEQ_NUM_EN
  localparam int SEQ_BYTES = 1;
`else
  localparam int SEQ_BYTES = 0;
`endif
  localparam int RES_W    = 80;              // {freq, duty, high, low}
  localparam int PL_BYTES = 12 + SEQ_BYTES;  // FRAME_TYPE .. last low byte
  localparam int PL_W     = PL_BYTES * 8;
  localparam int LAST_IDX = PL_BYTES + 2;    // index of CS

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               pend_full_q, pend_full_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [RES_W-1:0]   sh_res_q, sh_res_d;
  logic [RES_W-1:0]   pend_res_q, pend_res_d;
  logic [RES_W-1:0]   fin_res, start_res;
  logic [PL_W-1:0]    pl_next;
  logic               xfer, last, start;
`ifdef PACKER_SEQ_NUM_EN
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         sh_seq_q, sh_seq_d;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PACKER_SEQ_NUM_EN
  function automatic logic [PL_W-1:0] payload(input logic [RES_W-1:0] r,
                                              input logic [7:0] seq);
    return {FRAME_TYPE, seq, r[79:48], r[47:40], 4'h0, r[39:20], 4'h0, r[19:0]};
  endfunction
`else
  function automatic logic [PL_W-1:0] payload(input logic [RES_W-1:0] r);
    return {FRAME_TYPE, r[79:48], r[47:40], 4'h0, r[39:20], 4'h0, r[19:0]};
  endfunction
`endif

  // Byte idx of a frame whose checksummed body is pl (MSB byte first).
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [PL_W-1:0] pl);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < PL_BYTES; i++) cs = cs + pl[i*8 +: 8];
    if (idx == 4'd0)                 return HDR0;
    else if (idx == 4'd1)            return HDR1;
    else if (idx == 4'(LAST_IDX))    return cs;
    else                             return pl[(PL_BYTES + 1 - int'(idx))*8 +: 8];
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_full_d = pend_full_q;
    drop_cnt_d  = drop_cnt_q;
    sh_res_d    = sh_res_q;
    pend_res_d  = pend_res_q;
    fin_res     = {freq_in, duty_in, high_in, low_in};
    start       = 1'b0;
    start_res   = sh_res_q;
    xfer        = tx_valid_q && tx_ready;
    last        = (idx_q == 4'(LAST_IDX));
`ifdef PACKER_SEQ_NUM_EN
    seq_d       = seq_q;
    sh_seq_d    = sh_seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (finish) begin
          start     = 1'b1;
          start_res = fin_res;
        end
      end
      SEND: begin
        if (xfer && last) begin
          // Frame done: chain straight into the next one when anything waits,
          // so tx_valid never drops between frames.
          if (pend_full_q) begin
            start     = 1'b1;
            start_res = pend_res_q;
            if (finish) pend_res_d  = fin_res;
            else        pend_full_d = 1'b0;
          end else if (finish) begin
            start     = 1'b1;
            start_res = fin_res;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q + 4'd1;
          if (finish) begin
            pend_res_d  = fin_res;
            pend_full_d = 1'b1;
            if (pend_full_q) drop_cnt_d = sat_inc8(drop_cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The shadow only loads at a frame start, so it is frozen while in flight.
    if (start) begin
      state_d  = SEND;
      idx_d    = 4'd0;
      sh_res_d = start_res;
`ifdef PACKER_SEQ_NUM_EN
      sh_seq_d = seq_q;
      seq_d    = seq_q + 8'd1;
`endif
    end

`ifdef PACKER_SEQ_NUM_EN
    pl_next = payload(sh_res_d, sh_seq_d);
`else
    pl_next = payload(sh_res_d);
`endif
    tx_valid_d = (state_d == SEND);
    tx_data_d  = tx_valid_d ? frame_byte(idx_d, pl_next) : 8'h00;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      pend_full_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
`ifdef PACKER_SEQ_NUM_EN
      seq_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      drop_cnt_q  <= drop_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
`ifdef PACKER_SEQ_NUM_EN
      seq_q       <= seq_d;
`endif
    end
  end

  // Result storage; meaningful only while the matching control flag says so
  always_ff @(posedge clk) begin
    sh_res_q   <= sh_res_d;
    pend_res_q <= pend_res_d;
`ifdef PACKER_SEQ_NUM_EN
    sh_seq_q   <= sh_seq_d;
`endif
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q == SEND) || pend_full_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_measure_result_packer.sv
module tb_measure_result_packer;

  typedef struct packed {
    logic [31:0] f;
    logic [7:0]  d;
    logic [19:0] h;
    logic [19:0] l;
  } res_t;

`ifdef PACKER_SEQ_NUM_EN
  localparam int FRAME_LEN = 16;
`else
  localparam int FRAME_LEN = 15;
`endif

  logic        clk = 1'b0;
  logic        rst, finish, tx_ready;
  logic [31:0] freq_in;
  logic [7:0]  duty_in;
  logic [19:0] high_in, low_in;
  logic [7:0]  tx_data, drop_cnt;
  logic        tx_valid, busy;

  always #5 clk = ~clk;

  measure_result_packer dut (
    .clk      (clk),
    .rst      (rst),
    .finish   (finish),
    .freq_in  (freq_in),
    .duty_in  (duty_in),
    .high_in  (high_in),
    .low_in   (low_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the byte stream still owed to the receiver, the pending
  // result, the drop count and the next sequence number.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       pend_v;
  res_t       pend;
  int         drops;
  int         seq_m;
  logic       after_rst;

  task automatic push_frame(input res_t r);
    logic [7:0] body[$];
    int s;
    body.push_back(8'h01);
`ifdef PACKER_SEQ_NUM_EN
    body.push_back(8'(seq_m));
    seq_m = (seq_m + 1) % 256;
`endif
    body.push_back(r.f[31:24]); body.push_back(r.f[23:16]);
    body.push_back(r.f[15:8]);  body.push_back(r.f[7:0]);
    body.push_back(r.d);
    body.push_back({4'h0, r.h[19:16]}); body.push_back(r.h[15:8]); body.push_back(r.h[7:0]);
    body.push_back({4'h0, r.l[19:16]}); body.push_back(r.l[15:8]); body.push_back(r.l[7:0]);
    s = 0;
    foreach (body[i]) s += int'(body[i]);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(8'(s % 256));
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic cycle(input logic fin, input logic rdy, input logic r, input res_t res);
    check("tx_valid", tx_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("tx_data", tx_data, exp_q[0]);
    check("busy", busy, (exp_q.size() > 0) || pend_v);
    check("drop_cnt", drop_cnt, drops);
    if (after_rst) check("tx_data_rst", tx_data, 8'h00);
    if (tx_valid === 1'b1 && rdy) got_q.push_back(tx_data);
    finish = fin; tx_ready = rdy; rst = r;
    freq_in = res.f; duty_in = res.d; high_in = res.h; low_in = res.l;
    @(posedge clk);
    after_rst = r;
    if (r) begin
      exp_q.delete(); pend_v = 1'b0; drops = 0; seq_m = 0;
    end else begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (pend_v) begin
          push_frame(pend);
          if (fin) pend = res; else pend_v = 1'b0;
        end else if (fin) begin
          push_frame(res);
        end
      end else if (fin) begin
        if (pend_v && drops < 255) drops++;
        pend = res; pend_v = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic res_t rand_res();
    res_t r;
    r.f = $urandom; r.d = 8'($urandom_range(0, 100));
    r.h = 20'($urandom); r.l = 20'($urandom);
    return r;
  endfunction

  res_t z, ref_res;

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, z);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1, z);
    cycle(1'b0, 1'b0, 1'b1, z);
  endtask

  // Compare the captured bytes with the hand-written frame for the fixed result.
  task automatic check_literal(input string tag, input logic [7:0] seqb, input logic [7:0] csb);
    logic [7:0] lit[$];
    lit = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h32,
            8'h00, 8'h61, 8'hA8, 8'h00, 8'h61, 8'hA8, 8'h30};
`ifdef PACKER_SEQ_NUM_EN
    lit.insert(3, seqb);
`endif
    lit[lit.size()-1] = csb;
    check({tag, "_len"}, got_q.size(), lit.size());
    foreach (lit[i]) if (i < got_q.size()) check(tag, got_q[i], lit[i]);
  endtask

  initial begin
    z = '0;
    ref_res.f = 32'd1000; ref_res.d = 8'd50; ref_res.h = 20'd25000; ref_res.l = 20'd25000;
    exp_q.delete(); pend_v = 1'b0; pend = '0; drops = 0; seq_m = 0; after_rst = 1'b1;
    rst = 1'b1; finish = 1'b0; tx_ready = 1'b0;
    freq_in = '0; duty_in = '0; high_in = '0; low_in = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Single frame with the reference result, ready always high
    idle(2, 1'b1);
    got_q.delete();
    cycle(1'b1, 1'b1, 1'b0, ref_res);
    idle(FRAME_LEN + 3, 1'b1);
    check_literal("single", 8'h00, 8'h30);
    check("single_idle_valid", tx_valid, 1'b0);
    check("single_idle_busy", busy, 1'b0);

    // Second frame: sequence byte advances (when enabled)
    got_q.delete();
    cycle(1'b1, 1'b1, 1'b0, ref_res);
    idle(FRAME_LEN + 3, 1'b1);
`ifdef PACKER_SEQ_NUM_EN
    check_literal("second", 8'h01, 8'h31);
`else
    check_literal("second", 8'h00, 8'h30);
`endif

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    got_q.delete();
    cycle(1'b1, 1'b1, 1'b0, ref_res);
    for (int i = 0; i < 4 * FRAME_LEN; i++) cycle(1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0, z);
    check_literal("bp", 8'h00, 8'h30);

    // Overflow: three results during one frame
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    idle(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    idle(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    idle(2 * FRAME_LEN, 1'b1);
    check("ovf_drop", drop_cnt, 8'd1);

    // Finish in the CS transfer cycle with the slot empty
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    idle(FRAME_LEN - 1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    check("cs_edge_valid", tx_valid, 1'b1);
    check("cs_edge_hdr0", tx_data, 8'hA5);
    check("cs_edge_drop", drop_cnt, 8'd0);
    idle(FRAME_LEN + 2, 1'b1);

    // Reset at byte index 6, with a finish in the same cycle
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, rand_res());
    cycle(1'b1, 1'b1, 1'b0, rand_res());   // fill the slot as well
    idle(5, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, rand_res());
    check("rst_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    got_q.delete();
    cycle(1'b1, 1'b1, 1'b0, ref_res);
    idle(FRAME_LEN + 2, 1'b1);
    check_literal("post_rst", 8'h00, 8'h30);

    // Drop counter saturation under a full stall
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, rand_res());
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, rand_res());
    check("drop_sat", drop_cnt, 8'd255);
    idle(3 * FRAME_LEN, 1'b1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 599) == 0, rand_res());
    idle(3 * FRAME_LEN, 1'b1);
    check("final_valid", tx_valid, 1'b0);
    check("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
